// File: rtl/sample_ram_capture_ctrl_if.sv
// Bus bundle for the sample RAM capture controller:
// sample stream in, RAM port A/B, and readout stream.
interface sample_ram_capture_ctrl_if;
   logic [63:0] Sample_Data;
   logic        Sample_Valid;

   logic [15:0] A_ADDR;
   logic [3:0]  A_Block_Address_vector;
   logic [63:0] A_DIN;
   logic        A_WEN;

   logic [15:0] B_ADDR;
   logic [3:0]  B_Block_Address_vector;
   logic [63:0] B_Output_Data;

   logic [63:0] Out_Data;
   logic        Out_Valid;
   logic        Out_Ready;
   logic        Out_Last;

   modport master (
      input  Sample_Data, Sample_Valid,
      input  B_Output_Data, Out_Ready,
      output A_ADDR, A_Block_Address_vector,
      output A_DIN, A_WEN,
      output B_ADDR, B_Block_Address_vector,
      output Out_Data, Out_Valid, Out_Last
   );

   modport slave (
      output Sample_Data, Sample_Valid,
      output B_Output_Data, Out_Ready,
      input  A_ADDR, A_Block_Address_vector,
      input  A_DIN, A_WEN,
      input  B_ADDR, B_Block_Address_vector,
      input  Out_Data, Out_Valid, Out_Last
   );
endinterface

// File: rtl/sample_ram_capture_ctrl.sv
// Trigger-based acquisition sequencer for the banked sample RAM:
// circular pre/post capture on port A, ordered readout via port B.
module sample_ram_capture_ctrl #(
   parameter int BANK_AW     = 10,
   parameter int NUM_BANKS   = 8,
   parameter int RD_LAT      = 1,
   parameter int OFIFO_DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        Arm,
   input  logic        Abort,
   input  logic [15:0] Pre_Len,
   input  logic [15:0] Post_Len,
   input  logic        Trigger,
   output logic        Busy,
   output logic        Triggered,
   output logic        Config_Error,
   sample_ram_capture_ctrl_if.master bus
);

   localparam int unsigned TOT = NUM_BANKS * (2 ** BANK_AW);
   localparam int PW = $clog2(TOT);
   localparam int OW = $clog2(OFIFO_DEPTH + 1);
   localparam int IW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
   localparam logic [OW:0] DEPTH_L = (OW + 1)'(OFIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_ARMED,
      S_POST,
      S_READ
   } state_t;

   state_t state, state_nx;

   logic [PW-1:0] wp, tp, rp;
   logic [15:0]   pre_len, post_len, cnt;
   logic [16:0]   n_tot, n_iss, n_pop;

   logic          a_wen_q;
   logic [PW-1:0] a_ptr_q;
   logic [63:0]   a_din_q;
   logic          trig_q;
   logic          cfg_err_q;

   logic [RD_LAT-1:0] rv;
   logic [3:0]        rb [RD_LAT];
   logic [63:0]       fq [OFIFO_DEPTH];
   logic [IW-1:0]     f_wr, f_rd;
   logic [OW-1:0]     occ, infl;

   logic cfg_ok, arm_take, wr_fire, trig_hit;
   logic pre_done, post_done;
   logic issue, push, pop, last_pop;
   logic out_valid;

   function automatic logic [3:0] bank_of(input logic [PW-1:0] p);
      return 4'(p >> BANK_AW);
   endfunction

   function automatic logic [15:0] word_of(input logic [PW-1:0] p);
      return 16'(p[BANK_AW-1:0]);
   endfunction

   function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
      return (i == IW'(OFIFO_DEPTH - 1)) ? '0 : i + IW'(1);
   endfunction

   always_comb begin
      cfg_ok   = (32'(Pre_Len) + 32'(Post_Len) <= TOT) &&
                 (Post_Len != 16'd0);
      arm_take = (state == S_IDLE) && Arm && !Abort;
      wr_fire  = bus.Sample_Valid && !Abort &&
                 (state inside {S_PRE, S_ARMED, S_POST});
      trig_hit = (state == S_ARMED) && Trigger && !Abort;
      pre_done = (pre_len == 16'd0) ||
                 (wr_fire && ({1'b0, cnt} + 17'd1 == {1'b0, pre_len}));
      post_done = wr_fire &&
                  ({1'b0, cnt} + 17'd1 == {1'b0, post_len});
   end

   // Read-issue credit: FIFO slots already taken plus reads in flight.
   always_comb begin
      infl = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         infl = infl + OW'(rv[i]);
      end
   end

   always_comb begin
      out_valid = (occ != '0);
      push      = rv[RD_LAT-1];
      pop       = out_valid && bus.Out_Ready;
      last_pop  = pop && (n_pop + 17'd1 == n_tot);
      // Hold off the first read while the final post write is in the RAM.
      issue     = (state == S_READ) && !Abort && !a_wen_q &&
                  (n_iss < n_tot) &&
                  (({1'b0, occ} + {1'b0, infl}) < DEPTH_L);
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (Abort) begin
         state_nx = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:  if (Arm && cfg_ok) state_nx = S_PRE;
            S_PRE:   if (pre_done) state_nx = S_ARMED;
            S_ARMED: if (Trigger) state_nx = S_POST;
            S_POST:  if (post_done) state_nx = S_READ;
            S_READ:  if (last_pop) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_comb begin
      Busy         = (state != S_IDLE);
      Triggered    = trig_q;
      Config_Error = cfg_err_q;

      bus.A_WEN                  = a_wen_q;
      bus.A_ADDR                 = word_of(a_ptr_q);
      bus.A_Block_Address_vector = bank_of(a_ptr_q);
      bus.A_DIN                  = a_din_q;

      bus.B_ADDR                 = word_of(rp);
      bus.B_Block_Address_vector = rb[RD_LAT-1];

      bus.Out_Valid = out_valid;
      bus.Out_Data  = fq[f_rd];
      bus.Out_Last  = out_valid && (n_pop + 17'd1 == n_tot);
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         wp        <= '0;
         tp        <= '0;
         cnt       <= '0;
         pre_len   <= '0;
         post_len  <= '0;
         a_wen_q   <= 1'b0;
         a_ptr_q   <= '0;
         a_din_q   <= '0;
         trig_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         a_wen_q <= wr_fire;
         if (wr_fire) begin
            a_ptr_q <= wp;
            a_din_q <= bus.Sample_Data;
            wp      <= wp + PW'(1);
         end

         if (state_nx != state) begin
            cnt <= '0;
         end else if (wr_fire && state != S_ARMED) begin
            cnt <= cnt + 16'd1;
         end

         if (arm_take) begin
            if (cfg_ok) begin
               pre_len   <= Pre_Len;
               post_len  <= Post_Len;
               cfg_err_q <= 1'b0;
               wp        <= '0;
            end else begin
               cfg_err_q <= 1'b1;
            end
         end

         // A sample written in the trigger cycle stays pre-trigger.
         if (trig_hit) begin
            tp     <= wp + PW'(wr_fire);
            trig_q <= 1'b1;
         end
         if (state_nx == S_IDLE) begin
            trig_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         rp    <= '0;
         n_tot <= '0;
         n_iss <= '0;
         n_pop <= '0;
         rv    <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            rb[i] <= '0;
         end
         for (int i = 0; i < OFIFO_DEPTH; i++) begin
            fq[i] <= '0;
         end
         f_wr <= '0;
         f_rd <= '0;
         occ  <= '0;
      end else begin
         if (state == S_POST && state_nx == S_READ) begin
            rp    <= tp - PW'(pre_len);
            n_tot <= {1'b0, pre_len} + {1'b0, post_len};
            n_iss <= '0;
            n_pop <= '0;
         end else begin
            if (issue) begin
               rp    <= rp + PW'(1);
               n_iss <= n_iss + 17'd1;
            end
            if (pop) begin
               n_pop <= n_pop + 17'd1;
            end
         end

         if (Abort) begin
            rv <= '0;
         end else begin
            rv[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
               rv[i] <= rv[i-1];
            end
         end
         rb[0] <= bank_of(rp);
         for (int i = 1; i < RD_LAT; i++) begin
            rb[i] <= rb[i-1];
         end

         if (Abort) begin
            f_wr <= '0;
            f_rd <= '0;
            occ  <= '0;
         end else begin
            if (push) begin
               fq[f_wr] <= bus.B_Output_Data;
               f_wr     <= nxt(f_wr);
            end
            if (pop) begin
               f_rd <= nxt(f_rd);
            end
            occ <= occ + OW'(push) - OW'(pop);
         end
      end
   end

endmodule

// File: tb/tb_sample_ram_capture_ctrl.sv
// Self-checking bench for sample_ram_capture_ctrl: RAM model,
// randomized captures and a queue-based window reference.
module tb_sample_ram_capture_ctrl;

   logic        CLK;
   logic        RSTn;
   logic        Arm;
   logic        Abort;
   logic [15:0] Pre_Len;
   logic [15:0] Post_Len;
   logic        Trigger;
   logic        Busy;
   logic        Triggered;
   logic        Config_Error;

   sample_ram_capture_ctrl_if bus ();

   sample_ram_capture_ctrl dut (
      .CLK          (CLK),
      .RSTn         (RSTn),
      .Arm          (Arm),
      .Abort        (Abort),
      .Pre_Len      (Pre_Len),
      .Post_Len     (Post_Len),
      .Trigger      (Trigger),
      .Busy         (Busy),
      .Triggered    (Triggered),
      .Config_Error (Config_Error),
      .bus          (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Eight banks of 1024 words, one-clock synchronous read, bank-muxed.
   logic [63:0] mem [8192];
   logic [63:0] dout [8];

   always @(posedge CLK) begin
      if (bus.A_WEN) begin
         mem[{bus.A_Block_Address_vector[2:0], bus.A_ADDR[9:0]}] <= bus.A_DIN;
      end
      for (int b = 0; b < 8; b++) begin
         dout[b] <= mem[{3'(b), bus.B_ADDR[9:0]}];
      end
   end

   assign bus.B_Output_Data = dout[bus.B_Block_Address_vector[2:0]];

   // Every accepted sample, in order, since the last accepted Arm.
   logic [63:0] hist [$];
   int          a_idx;
   bit          mon_on;
   bit          wrap_seen;
   bit          a_prev_v;
   logic [3:0]  a_prev_bank;
   logic [15:0] a_prev_addr;

   always @(negedge CLK) begin
      if (mon_on && RSTn && bus.A_WEN) begin
         if (a_idx < hist.size()) begin
            chk("a_din", bus.A_DIN, hist[a_idx]);
            chk("a_addr", 64'(bus.A_ADDR), 64'(a_idx % 1024));
            chk("a_bank", 64'(bus.A_Block_Address_vector),
                64'((a_idx / 1024) % 8));
         end else begin
            chk("a_extra_write", 64'(a_idx), 64'(hist.size()));
         end
         if (a_prev_v && a_prev_bank == 4'd7 && a_prev_addr == 16'd1023 &&
             bus.A_Block_Address_vector == 4'd0 && bus.A_ADDR == 16'd0) begin
            wrap_seen = 1'b1;
         end
         a_prev_v    = 1'b1;
         a_prev_bank = bus.A_Block_Address_vector;
         a_prev_addr = bus.A_ADDR;
         a_idx++;
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_a_wen"}, 64'(bus.A_WEN), 0);
      chk({tag, "_a_addr"}, 64'(bus.A_ADDR), 0);
      chk({tag, "_a_bank"}, 64'(bus.A_Block_Address_vector), 0);
      chk({tag, "_a_din"}, bus.A_DIN, 0);
      chk({tag, "_b_addr"}, 64'(bus.B_ADDR), 0);
      chk({tag, "_b_bank"}, 64'(bus.B_Block_Address_vector), 0);
      chk({tag, "_out_data"}, bus.Out_Data, 0);
      chk({tag, "_out_valid"}, 64'(bus.Out_Valid), 0);
      chk({tag, "_out_last"}, 64'(bus.Out_Last), 0);
      chk({tag, "_busy"}, 64'(Busy), 0);
      chk({tag, "_triggered"}, 64'(Triggered), 0);
      chk({tag, "_cfg_err"}, 64'(Config_Error), 0);
   endtask

   task automatic reject(input int pre, input int post);
      @(negedge CLK);
      Arm = 1'b1;
      Pre_Len = 16'(pre);
      Post_Len = 16'(post);
      @(negedge CLK);
      Arm = 1'b0;
      chk("rej_cfg_err", 64'(Config_Error), 1);
      chk("rej_busy", 64'(Busy), 0);
      @(negedge CLK);
      chk("rej_busy_hold", 64'(Busy), 0);
   endtask

   // phase: 1 pre-trigger fill, 2 armed, 3 post-trigger, 4 readout
   task automatic capture(input int pre, input int post, input int trig_at,
                          input bit rnd, input int rmode,
                          input int abort_after, input bit rst_post,
                          input logic [63:0] base);
      int phase, cnt, armed_w, k, n, got, cyc;
      logic [63:0] exp_q [$];
      logic [63:0] data, prev_d;
      bit v, trig, rdy, stall;

      @(negedge CLK);
      Arm = 1'b1;
      Pre_Len = 16'(pre);
      Post_Len = 16'(post);
      @(negedge CLK);
      Arm = 1'b0;
      hist.delete();
      a_idx = 0;
      a_prev_v = 1'b0;
      mon_on = 1'b1;
      chk("arm_busy", 64'(Busy), 1);
      chk("arm_cfg_err", 64'(Config_Error), 0);
      chk("arm_triggered", 64'(Triggered), 0);

      phase = 1;
      cnt = 0;
      armed_w = 0;
      k = 0;
      cyc = 0;
      while (phase != 4 && cyc < 20000) begin
         v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (phase == 1 && pre == 0) v = 1'b0;
         trig = (phase == 2 && armed_w == trig_at);
         data = base + 64'(hist.size());
         bus.Sample_Valid = v;
         bus.Sample_Data = data;
         Trigger = trig || (phase == 1 && rnd && $urandom_range(0, 1) == 1);
         if (rnd) begin
            Arm = ($urandom_range(0, 7) == 0);
            Pre_Len = 16'($urandom);
            Post_Len = 16'($urandom);
         end
         if (v) hist.push_back(data);
         case (phase)
            1: begin
               if (pre == 0) phase = 2;
               else if (v) begin
                  cnt++;
                  if (cnt == pre) phase = 2;
               end
            end
            2: begin
               if (trig) begin
                  k = hist.size();
                  phase = 3;
                  cnt = 0;
               end else if (v) armed_w++;
            end
            3: begin
               if (v) begin
                  cnt++;
                  if (cnt == post) phase = 4;
               end
            end
            default: ;
         endcase
         cyc++;
         @(negedge CLK);
         if (rst_post && phase == 3 && cnt >= 1) begin
            mon_on = 1'b0;
            #2 RSTn = 1'b0;
            #1 check_zero("rst_mid");
            bus.Sample_Valid = 1'b0;
            Trigger = 1'b0;
            Arm = 1'b0;
            @(negedge CLK);
            @(negedge CLK);
            RSTn = 1'b1;
            return;
         end
      end
      Trigger = 1'b0;
      Arm = 1'b0;
      bus.Sample_Valid = 1'b0;
      if (phase != 4) begin
         chk("capture_timeout", 64'(phase), 4);
         mon_on = 1'b0;
         return;
      end

      n = pre + post;
      for (int i = 0; i < n; i++) exp_q.push_back(hist[k - pre + i]);
      chk("rd_triggered", 64'(Triggered), 1);

      got = 0;
      cyc = 0;
      stall = 1'b0;
      prev_d = '0;
      while (got < n && cyc < 40000) begin
         if (abort_after > 0 && got == abort_after) begin
            Abort = 1'b1;
            bus.Out_Ready = 1'b0;
            @(negedge CLK);
            Abort = 1'b0;
            chk("abort_busy", 64'(Busy), 0);
            chk("abort_out_valid", 64'(bus.Out_Valid), 0);
            chk("abort_triggered", 64'(Triggered), 0);
            chk("abort_a_wen", 64'(bus.A_WEN), 0);
            mon_on = 1'b0;
            return;
         end
         if (stall) begin
            chk("hold_valid", 64'(bus.Out_Valid), 1);
            chk("hold_data", bus.Out_Data, prev_d);
         end
         case (rmode)
            0: rdy = 1'b1;
            1: rdy = $urandom_range(0, 1) == 1;
            default: rdy = (cyc % 3 == 2);
         endcase
         bus.Out_Ready = rdy;
         bus.Sample_Valid = $urandom_range(0, 1) == 1;
         bus.Sample_Data = {$urandom, $urandom};
         Arm = rnd && ($urandom_range(0, 7) == 0);
         stall = bus.Out_Valid && !rdy;
         prev_d = bus.Out_Data;
         if (bus.Out_Valid && rdy) begin
            chk("out_data", bus.Out_Data, exp_q[got]);
            chk("out_last", 64'(bus.Out_Last), 64'(got == n - 1));
            got++;
         end
         cyc++;
         @(negedge CLK);
      end
      bus.Out_Ready = 1'b0;
      bus.Sample_Valid = 1'b0;
      Arm = 1'b0;
      if (got < n) chk("readout_timeout", 64'(got), 64'(n));
      chk("done_busy", 64'(Busy), 0);
      chk("done_out_valid", 64'(bus.Out_Valid), 0);
      chk("done_triggered", 64'(Triggered), 0);
      chk("done_cfg_err", 64'(Config_Error), 0);
      mon_on = 1'b0;
   endtask

   initial begin
      RSTn = 1'b0;
      Arm = 1'b0;
      Abort = 1'b0;
      Pre_Len = '0;
      Post_Len = '0;
      Trigger = 1'b0;
      bus.Sample_Valid = 1'b0;
      bus.Sample_Data = '0;
      bus.Out_Ready = 1'b0;
      mon_on = 1'b0;
      wrap_seen = 1'b0;
      repeat (3) @(negedge CLK);
      check_zero("reset");
      RSTn = 1'b1;
      @(negedge CLK);

      capture(4, 4, 6, 0, 0, 0, 0, 64'd0);
      capture(0, 3, 0, 0, 0, 0, 0, 64'd100);

      wrap_seen = 1'b0;
      capture(8, 8, 8192, 0, 0, 0, 0, 64'h1_0000);
      chk("bank_wrap", 64'(wrap_seen), 1);

      capture(8, 8, 3, 0, 2, 0, 0, 64'hA000);

      reject(8000, 200);
      reject(3, 0);
      capture(2, 2, 1, 0, 0, 0, 0, 64'hB000);

      capture(4, 4, 2, 0, 0, 3, 0, 64'hC000);
      capture(4, 4, 2, 0, 0, 0, 1, 64'hD000);
      capture(3, 5, 4, 1, 1, 0, 0, 64'hE000);

      capture(4096, 4096, 100, 0, 1, 0, 0, 64'hF_0000);

      for (int r = 0; r < 8; r++) begin
         capture($urandom_range(0, 12), $urandom_range(1, 12),
                 $urandom_range(0, 20), 1, 1 + (r % 2), 0, 0,
                 {$urandom, $urandom});
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
